// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL dynamic-reconfiguration controller.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    StRstPll   = 2'd0,
    StWaitLock = 2'd1,
    StRun      = 2'd2,
    StSettle   = 2'd3
  } pll_state_e;

  localparam int unsigned CntW = 16;

  // Power-on dynamic codes.
  localparam logic [3:0] PsdaInitDefault   = 4'b0000;
  localparam logic [3:0] DutydaInitDefault = 4'b1000;
  localparam logic [3:0] FdlyInitDefault   = 4'b0000;

  // Increment that sticks at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clkin,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async level through two flops; both clear on reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL sequencing and dynamic phase/duty/fine-delay update controller.
module pll_dyn_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter logic [3:0]  PSDA_INIT     = PsdaInitDefault,
  parameter logic [3:0]  DUTYDA_INIT   = DutydaInitDefault,
  parameter logic [3:0]  FDLY_INIT     = FdlyInitDefault
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic [3:0] fdly,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_psda,
  input  logic [3:0] req_dutyda,
  input  logic [3:0] req_fdly,
  output logic       locked,
  output logic       req_err,
  output logic [7:0] relock_cnt
);

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);

  pll_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      psda_q, psda_d;
  logic [3:0]      dutyda_q, dutyda_d;
  logic [3:0]      fdly_q, fdly_d;
  logic            err_q, err_d;
  logic [7:0]      relock_q, relock_d;
  logic            lock;

  sync_2ff u_lock_sync (
    .clkin (clkin),
    .reset (reset),
    .d_i   (pll_lock),
    .q_o   (lock)
  );

  // Next-state, counter, code and status computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    psda_d   = psda_q;
    dutyda_d = dutyda_q;
    fdly_d   = fdly_q;
    err_d    = 1'b0;
    relock_d = relock_q;

    case (state_q)
      StRstPll: begin
        if (cnt_q == RstLast) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lock) begin
          state_d = StRun;
        end else if (cnt_q == TimeoutLast) begin
          state_d  = StRstPll;
          relock_d = sat_inc8(relock_q);
        end
      end
      StRun: begin
        if (req_valid) begin
          if (req_dutyda != 4'd0) begin
            psda_d   = req_psda;
            dutyda_d = req_dutyda;
            fdly_d   = req_fdly;
            state_d  = StSettle;
          end else begin
            err_d = 1'b1;
          end
        end
        // Lock loss overrides the settle transition, but any accepted codes still land.
        if (!lock) begin
          state_d  = StRstPll;
          relock_d = sat_inc8(relock_q);
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) state_d = lock ? StRun : StWaitLock;
      end
      default: state_d = StRstPll;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q  <= StRstPll;
      cnt_q    <= '0;
      psda_q   <= PSDA_INIT;
      dutyda_q <= DUTYDA_INIT;
      fdly_q   <= FDLY_INIT;
      err_q    <= 1'b0;
      relock_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      psda_q   <= psda_d;
      dutyda_q <= dutyda_d;
      fdly_q   <= fdly_d;
      err_q    <= err_d;
      relock_q <= relock_d;
    end
  end

  assign pll_reset  = (state_q == StRstPll);
  assign req_ready  = (state_q == StRun);
  assign locked     = (state_q == StRun);
  assign psda       = psda_q;
  assign dutyda     = dutyda_q;
  assign fdly       = fdly_q;
  assign req_err    = err_q;
  assign relock_cnt = relock_q;

endmodule
